serial_rx_param: RTL and testbench
==================================

// Module: serial_rx_param
// PURPOSE
//  Parametrised 1-wire serial frame receiver: start bit, DATA_W data bits LSB first,
//  optional parity bit, optional stop bit. Supports clocks-per-bit oversampling with
//  mid-bit sampling and a one-entry valid/ready output register with overrun detection.
//  Sits between a serial pin (or transmitter loopback) and the consuming byte/word logic.
// PARAMETERS
//  DATA_W        7  data bits per frame (1..16)
//  CLKS_PER_BIT  1  clk cycles per serial bit (>=1); 1 = one bit per clk
//  PARITY_MODE   1  0 none, 1 even, 2 odd (constants in serial_pkg)
//  STOP_EN       0  1 = one stop bit expected after parity/data, checked for '1'
// PORTS
//  clk            in   1       clock, rising edge
//  rstn           in   1       reset, asynchronous, active-low
//  serial_in      in   1       serial line, idle high
//  rx_data        out  DATA_W  received word, valid while rx_valid
//  rx_valid       out  1       holding register full
//  rx_ready       in   1       consumer accepts rx_data when rx_valid&&rx_ready
//  rx_parity_err  out  1       parity mismatch for word in rx_data (0 if PARITY_MODE=0)
//  rx_frame_err   out  1       stop bit sampled 0 for word in rx_data (0 if STOP_EN=0)
//  overrun        out  1       one-cycle pulse: frame completed while register full
//  busy           out  1       FSM not in IDLE
// BEHAVIOUR
//  Reset: rx_data=0, rx_valid=0, rx_parity_err=0, rx_frame_err=0, overrun=0, busy=0,
//   FSM=IDLE, line delay reg serial_d=1, counters 0. Reset mid-frame aborts frame silently.
//  HALF = CLKS_PER_BIT/2 (integer). Start edge at cycle T: in IDLE, serial_d==1 && serial_in==0.
//  FSM: IDLE -> START -> DATA -> [PARITY] -> [STOP] -> IDLE.
//   START: if HALF>0, re-sample serial_in at T+HALF; 1 = false start -> IDLE, no outputs.
//    If HALF==0, START is skipped (DATA entered directly).
//   Data bit k (0..DATA_W-1) sampled at T+(k+1)*CLKS_PER_BIT+HALF into bit k of shift reg.
//   Parity bit sampled at slot DATA_W+1, stop bit at next slot, same formula.
//   CLKS_PER_BIT=1, PARITY_MODE=1, STOP_EN=0: bit0 sampled at T+1, parity at T+DATA_W+1.
//  Parity: even -> error if XOR(data,parity_bit)=1; odd -> error if XOR(data,parity_bit)=0.
//  Completion on the edge sampling the final frame bit; FSM returns to IDLE on that edge;
//   a new start edge is accepted from the next cycle (serial_d must be 1).
//  Output register on completion:
//   - empty, or rx_valid&&rx_ready this cycle: load rx_data/flags, rx_valid=1 next cycle.
//   - full and not accepted: frame dropped, old word and flags kept, overrun=1 for 1 cycle.
//  rx_valid&&rx_ready with no completion: rx_valid=0 next cycle; rx_data/flags hold.
//  rx_data/flags stable while rx_valid=1 and not accepted.
//  Line changes during a frame outside sample points are ignored; no resync mid-frame.
//  Bit-cycle counter width $clog2(CLKS_PER_BIT+1); bit index width $clog2(DATA_W+3).
// STRUCTURE
//  serial_pkg: PARITY_NONE/EVEN/ODD localparams, FSM state encodings (ST_IDLE, ST_START,
//   ST_DATA, ST_PARITY, ST_STOP), shared with the matching transmitter.
//  Sub-module serial_bit_timer: clocks-per-bit counter, restarted on start edge,
//   emits sample_tick at HALF and every CLKS_PER_BIT thereafter.
//  Top: edge detect, FSM, shift/parity accumulation, output holding register.
// TESTING
//  1 DATA_W=7,CPB=1,even: idle 1, start 0, bits 1,0,1,0,1,0,1, parity 0 -> rx_valid=1
//    cycle after parity, rx_data=7'h55, rx_parity_err=0.
//  2 Same frame, parity bit 1 -> rx_data=7'h55, rx_parity_err=1.
//  3 DATA_W=8,CPB=4,odd,STOP_EN=1: 0xA5, parity 1, stop 1 -> rx_data=8'hA5, both errs 0;
//    stop 0 instead -> rx_frame_err=1.
//  4 CPB=4: line low for 1 clk then high -> false start, busy drops by T+2, no rx_valid.
//  5 rx_ready=0, send 0x12 then 0x34 -> overrun pulses 1 cycle at second completion,
//    rx_data stays 0x12; rx_ready=1 same cycle as a completion -> new word loaded, no overrun.
//  6 Assert rstn=0 mid data bits -> all outputs reset value; next clean frame received OK.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared definitions for the serial receiver/transmitter pair:
// parity mode selectors and frame FSM state encodings.
package serial_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } serial_state_e;

endpackage

// File: rtl/serial_bit_timer.sv
// Clocks-per-bit timer: restarted on the start edge, ticks at the half-bit
// point (or one full bit later when HALF is 0) and every bit period after.
module serial_bit_timer #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic clk,
    input  logic rstn,
    input  logic restart,
    output logic sample_tick
);

    localparam int HALF  = CLKS_PER_BIT / 2;
    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);
    // Preload so the first tick lands HALF cycles after the start edge.
    localparam logic [CNT_W-1:0] FIRST = (HALF == 0) ? '0 : CNT_W'(CLKS_PER_BIT - HALF);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (restart) begin
            cnt <= FIRST;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign sample_tick = (cnt == LAST);

endmodule

// File: rtl/serial_rx_param.sv
// Parametrised serial frame receiver: start, DATA_W data bits LSB first,
// optional parity and stop bits, one-entry valid/ready output register.
module serial_rx_param
    import serial_pkg::*;
#(
    parameter int DATA_W       = 7,
    parameter int CLKS_PER_BIT = 1,
    parameter int PARITY_MODE  = 1,
    parameter int STOP_EN      = 0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              serial_in,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              rx_parity_err,
    output logic              rx_frame_err,
    output logic              overrun,
    output logic              busy
);

    localparam int HALF  = CLKS_PER_BIT / 2;
    localparam int IDX_W = $clog2(DATA_W + 3);

    serial_state_e     state;
    logic              serial_d;
    logic [IDX_W-1:0]  bit_idx;
    logic [DATA_W-1:0] shreg;
    logic              par_acc;
    logic              perr_q;
    logic              tick;

    logic              start_edge;
    logic              last_bit;
    logic [DATA_W-1:0] word_in;
    logic              par_bit_err;
    logic              done;
    logic [DATA_W-1:0] done_word;
    logic              done_perr;
    logic              done_ferr;

    serial_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk        (clk),
        .rstn       (rstn),
        .restart    (start_edge),
        .sample_tick(tick)
    );

    always_comb begin
        start_edge  = (state == ST_IDLE) && serial_d && !serial_in;
        last_bit    = (bit_idx == IDX_W'(DATA_W - 1));
        word_in     = shreg | (DATA_W'(serial_in) << bit_idx);
        par_bit_err = (PARITY_MODE == PARITY_ODD) ? ~(par_acc ^ serial_in)
                                                  :  (par_acc ^ serial_in);
        done      = 1'b0;
        done_word = shreg;
        done_perr = perr_q;
        done_ferr = 1'b0;
        // The frame completes on whichever edge samples its final bit.
        case (state)
            ST_DATA: begin
                if (tick && last_bit && PARITY_MODE == PARITY_NONE && STOP_EN == 0) begin
                    done      = 1'b1;
                    done_word = word_in;
                    done_perr = 1'b0;
                end
            end
            ST_PARITY: begin
                if (tick && STOP_EN == 0) begin
                    done      = 1'b1;
                    done_perr = par_bit_err;
                end
            end
            ST_STOP: begin
                if (tick) begin
                    done      = 1'b1;
                    done_ferr = ~serial_in;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= ST_IDLE;
            serial_d <= 1'b1;
            bit_idx  <= '0;
            shreg    <= '0;
            par_acc  <= 1'b0;
            perr_q   <= 1'b0;
        end else begin
            serial_d <= serial_in;
            case (state)
                ST_IDLE: begin
                    if (start_edge) begin
                        bit_idx <= '0;
                        shreg   <= '0;
                        par_acc <= 1'b0;
                        perr_q  <= 1'b0;
                        if (HALF > 0) state <= ST_START;
                        else          state <= ST_DATA;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        if (serial_in) state <= ST_IDLE;
                        else           state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        shreg   <= word_in;
                        par_acc <= par_acc ^ serial_in;
                        bit_idx <= bit_idx + IDX_W'(1);
                        if (last_bit) begin
                            if (PARITY_MODE != PARITY_NONE) state <= ST_PARITY;
                            else if (STOP_EN != 0)          state <= ST_STOP;
                            else                            state <= ST_IDLE;
                        end
                    end
                end
                ST_PARITY: begin
                    if (tick) begin
                        perr_q <= par_bit_err;
                        if (STOP_EN != 0) state <= ST_STOP;
                        else              state <= ST_IDLE;
                    end
                end
                ST_STOP: begin
                    if (tick) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // A completing frame may load in the same cycle the held word is accepted.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            rx_parity_err <= 1'b0;
            rx_frame_err  <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (done) begin
                if (!rx_valid || rx_ready) begin
                    rx_data       <= done_word;
                    rx_parity_err <= done_perr;
                    rx_frame_err  <= done_ferr;
                    rx_valid      <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_serial_rx_param.sv
// Directed bench for serial_rx_param: a 7-bit/1-clk/even instance and an
// 8-bit/4-clk/odd/stop instance driven from one linear stimulus sequence.
module tb_serial_rx_param;
    import serial_pkg::*;

    logic       clk = 1'b0;
    logic       rstn;
    logic       ser_a, ser_b;
    logic       rdy_a, rdy_b;
    logic [6:0] data_a;
    logic [7:0] data_b;
    logic       vld_a, vld_b, perr_a, perr_b, ferr_a, ferr_b;
    logic       ovr_a, ovr_b, busy_a, busy_b;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    serial_rx_param #(.DATA_W(7), .CLKS_PER_BIT(1), .PARITY_MODE(PARITY_EVEN), .STOP_EN(0)) u_a (
        .clk(clk), .rstn(rstn), .serial_in(ser_a), .rx_data(data_a), .rx_valid(vld_a),
        .rx_ready(rdy_a), .rx_parity_err(perr_a), .rx_frame_err(ferr_a), .overrun(ovr_a),
        .busy(busy_a));

    serial_rx_param #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_MODE(PARITY_ODD), .STOP_EN(1)) u_b (
        .clk(clk), .rstn(rstn), .serial_in(ser_b), .rx_data(data_b), .rx_valid(vld_b),
        .rx_ready(rdy_b), .rx_parity_err(perr_b), .rx_frame_err(ferr_b), .overrun(ovr_b),
        .busy(busy_b));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One bit per clock; rdy_last raises rx_ready only in the completion cycle.
    task automatic send_a(input logic [6:0] d, input logic p, input logic rdy_last);
        @(negedge clk); ser_a = 1'b0;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk); ser_a = d[k];
        end
        @(negedge clk); ser_a = p; rdy_a = rdy_last;
        @(negedge clk); ser_a = 1'b1; rdy_a = 1'b0;
    endtask

    task automatic drive_b(input logic v);
        ser_b = v;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_b(input logic [7:0] d, input logic p, input logic s);
        @(negedge clk);
        drive_b(1'b0);
        for (int k = 0; k < 8; k++) drive_b(d[k]);
        drive_b(p);
        drive_b(s);
        ser_b = 1'b1;
    endtask

    task automatic accept_a();
        @(negedge clk); rdy_a = 1'b1;
        @(negedge clk); rdy_a = 1'b0;
        chk("a_accept_clears_valid", vld_a, 0);
    endtask

    task automatic accept_b();
        @(negedge clk); rdy_b = 1'b1;
        @(negedge clk); rdy_b = 1'b0;
        chk("b_accept_clears_valid", vld_b, 0);
    endtask

    initial begin
        rstn = 1'b0; ser_a = 1'b1; ser_b = 1'b1; rdy_a = 1'b0; rdy_b = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_a_valid", vld_a, 0);
        chk("rst_a_data", data_a, 0);
        chk("rst_a_busy", busy_a, 0);
        chk("rst_a_overrun", ovr_a, 0);
        chk("rst_b_valid", vld_b, 0);
        chk("rst_b_data", data_b, 0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // Even parity, correct parity bit
        send_a(7'h55, 1'b0, 1'b0);
        chk("t1_valid", vld_a, 1);
        chk("t1_data", data_a, 7'h55);
        chk("t1_perr", perr_a, 0);
        chk("t1_ferr", ferr_a, 0);
        chk("t1_overrun", ovr_a, 0);
        accept_a();

        // Even parity, wrong parity bit
        send_a(7'h55, 1'b1, 1'b0);
        chk("t2_valid", vld_a, 1);
        chk("t2_data", data_a, 7'h55);
        chk("t2_perr", perr_a, 1);
        accept_a();

        // Oversampled odd-parity frames with stop bit
        send_b(8'hA5, 1'b1, 1'b1);
        chk("t3_valid", vld_b, 1);
        chk("t3_data", data_b, 8'hA5);
        chk("t3_perr", perr_b, 0);
        chk("t3_ferr", ferr_b, 0);
        accept_b();
        send_b(8'hA5, 1'b1, 1'b0);
        chk("t3s_data", data_b, 8'hA5);
        chk("t3s_perr", perr_b, 0);
        chk("t3s_ferr", ferr_b, 1);
        accept_b();
        send_b(8'hA5, 1'b0, 1'b1);
        chk("t3p_perr", perr_b, 1);
        chk("t3p_ferr", ferr_b, 0);
        accept_b();

        // False start: low for one clock only
        @(negedge clk); ser_b = 1'b0;
        @(negedge clk); ser_b = 1'b1;
        chk("t4_busy_T", busy_b, 1);
        @(negedge clk);
        chk("t4_busy_T1", busy_b, 1);
        @(negedge clk);
        chk("t4_busy_T2", busy_b, 0);
        repeat (50) @(negedge clk);
        chk("t4_no_valid", vld_b, 0);
        chk("t4_idle", busy_b, 0);

        // Overrun while full, then load in the same cycle as acceptance
        send_a(7'h12, 1'b0, 1'b0);
        chk("t5_first_valid", vld_a, 1);
        chk("t5_first_data", data_a, 7'h12);
        send_a(7'h34, 1'b1, 1'b0);
        chk("t5_overrun", ovr_a, 1);
        chk("t5_data_kept", data_a, 7'h12);
        chk("t5_valid_kept", vld_a, 1);
        @(negedge clk);
        chk("t5_overrun_pulse", ovr_a, 0);
        send_a(7'h0F, 1'b0, 1'b1);
        chk("t5_swap_data", data_a, 7'h0F);
        chk("t5_swap_valid", vld_a, 1);
        chk("t5_swap_no_ovr", ovr_a, 0);

        // Reset in the middle of data bits
        @(negedge clk); ser_a = 1'b0;
        @(negedge clk); ser_a = 1'b1;
        @(negedge clk); ser_a = 1'b0;
        @(negedge clk); ser_a = 1'b1;
        chk("t6_busy_pre", busy_a, 1);
        @(negedge clk); rstn = 1'b0;
        #1;
        chk("t6_valid", vld_a, 0);
        chk("t6_data", data_a, 0);
        chk("t6_busy", busy_a, 0);
        chk("t6_perr", perr_a, 0);
        chk("t6_overrun", ovr_a, 0);
        ser_a = 1'b1;
        @(negedge clk); rstn = 1'b1;
        @(negedge clk);
        send_a(7'h2A, 1'b1, 1'b0);
        chk("t6_after_valid", vld_a, 1);
        chk("t6_after_data", data_a, 7'h2A);
        chk("t6_after_perr", perr_a, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
